// File: rtl/cc_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// cc_pkg : frame geometry and stream states shared by the mask
//          streamer and connected_components.
// Rev 1.0
// ------------------------------------------------------------------
package cc_pkg;

    localparam int DEFAULT_WIDTH  = 320;
    localparam int DEFAULT_HEIGHT = 180;

    // Bits needed to address one frame bank.
    function automatic int fb_size(input int width, input int height);
        return $clog2(width * height);
    endfunction

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_CC = 3'd1,
        START   = 3'd2,
        STREAM  = 3'd3,
        DRAIN   = 3'd4
    } stream_state_t;

endpackage
`default_nettype wire

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
`default_nettype none
// ------------------------------------------------------------------
// xilinx_true_dual_port_read_first_2_clock_ram : block RAM with a
//          write port A and a 2-cycle registered read port B.
// Rev 1.0
// ------------------------------------------------------------------
module xilinx_true_dual_port_read_first_2_clock_ram #(
    parameter int RAM_WIDTH = 1,
    parameter int RAM_DEPTH = 1024
) (
    input  logic                         clka,
    input  logic                         ena,
    input  logic                         wea,
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         clkb,
    input  logic                         enb,
    input  logic                         regceb,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    output logic [RAM_WIDTH-1:0]         doutb
);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data_b_q;

    always_ff @(posedge clka) begin
        if (ena && wea) begin
            mem[addra] <= dina;
        end
    end

    always_ff @(posedge clkb) begin
        if (enb) begin
            ram_data_b_q <= mem[addrb];
        end
    end

    always_ff @(posedge clkb) begin
        if (regceb) begin
            doutb <= ram_data_b_q;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mask_frame_streamer.sv
`default_nettype none
// ------------------------------------------------------------------
// mask_frame_streamer : double-buffered 1-bit mask frame store that
//          replays a completed frame as a raster stream.
// Rev 1.0
// ------------------------------------------------------------------
module mask_frame_streamer
    import cc_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] wr_x_in,
    input  logic [9:0]  wr_y_in,
    input  logic        wr_mask_in,
    input  logic        wr_valid_in,
    input  logic        wr_frame_done_in,
    input  logic        cc_busy_in,
    input  logic        stall_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        mask_out,
    output logic        valid_out,
    output logic        new_frame_out,
    output logic        busy_out,
    output logic [15:0] frames_dropped_out
);

    localparam int FB_SIZE = fb_size(WIDTH, HEIGHT);
    localparam int ADDR_W  = FB_SIZE + 1;
    // Bank bit sits above FB_SIZE, so the array spans the full power of two.
    localparam int RAM_DEPTH = 2 ** ADDR_W;
    localparam logic [10:0] X_END  = 11'(WIDTH);
    localparam logic [9:0]  Y_END  = 10'(HEIGHT);
    localparam logic [10:0] LAST_X = 11'(WIDTH - 1);
    localparam logic [9:0]  LAST_Y = 10'(HEIGHT - 1);

    stream_state_t state_q, state_d;
    logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [10:0]   rd_x_q, rd_x_d, s1_x_q, s1_x_d, s2_x_q, s2_x_d;
    logic [9:0]    rd_y_q, rd_y_d, s1_y_q, s1_y_d, s2_y_q, s2_y_d;
    logic          s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic          new_frame_q, new_frame_d, busy_q, busy_d;
    logic [15:0]   dropped_q, dropped_d;

    logic               w_wr_en, w_issue, w_drop, w_ram_dout;
    logic [FB_SIZE-1:0] w_wr_off, w_rd_off;

    assign w_wr_en  = wr_valid_in && (wr_x_in < X_END) && (wr_y_in < Y_END);
    assign w_wr_off = FB_SIZE'(wr_y_in) * FB_SIZE'(WIDTH) + FB_SIZE'(wr_x_in);
    assign w_rd_off = FB_SIZE'(rd_y_q) * FB_SIZE'(WIDTH) + FB_SIZE'(rd_x_q);

    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        rd_x_d    = rd_x_q;
        rd_y_d    = rd_y_q;
        w_issue   = 1'b0;
        w_drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_frame_done_in) begin
                    rd_bank_d = wr_bank_q;
                    wr_bank_d = ~wr_bank_q;
                    state_d   = WAIT_CC;
                end
            end
            WAIT_CC: begin
                // A fresher frame replaces the waiting one before any handoff.
                if (wr_frame_done_in) begin
                    rd_bank_d = wr_bank_q;
                    wr_bank_d = ~wr_bank_q;
                    w_drop    = 1'b1;
                end else if (!cc_busy_in) begin
                    state_d = START;
                end
            end
            START: begin
                rd_x_d  = '0;
                rd_y_d  = '0;
                state_d = STREAM;
            end
            STREAM: begin
                w_drop = wr_frame_done_in;
                if (!stall_in) begin
                    w_issue = 1'b1;
                    if (rd_x_q == LAST_X) begin
                        rd_x_d = '0;
                        if (rd_y_q == LAST_Y) begin
                            state_d = DRAIN;
                        end else begin
                            rd_y_d = rd_y_q + 10'd1;
                        end
                    end else begin
                        rd_x_d = rd_x_q + 11'd1;
                    end
                end
            end
            DRAIN: begin
                w_drop = wr_frame_done_in;
                if (!s1_valid_q && (!s2_valid_q || !stall_in)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        dropped_d = dropped_q;
        if (w_drop && dropped_q != 16'hFFFF) begin
            dropped_d = dropped_q + 16'd1;
        end
        new_frame_d = (state_q == WAIT_CC) && (state_d == START);
        busy_d      = (state_d != IDLE);

        // Pipeline advances in lockstep with the RAM output enables.
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s2_valid_d = s2_valid_q;
        s2_x_d     = s2_x_q;
        s2_y_d     = s2_y_q;
        if (!stall_in) begin
            s1_valid_d = w_issue;
            s1_x_d     = rd_x_q;
            s1_y_d     = rd_y_q;
            s2_valid_d = s1_valid_q;
            s2_x_d     = s1_x_q;
            s2_y_d     = s1_y_q;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_x_q      <= '0;
            rd_y_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_x_q      <= '0;
            s2_y_q      <= '0;
            new_frame_q <= 1'b0;
            busy_q      <= 1'b0;
            dropped_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            rd_x_q      <= rd_x_d;
            rd_y_q      <= rd_y_d;
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s2_valid_q  <= s2_valid_d;
            s2_x_q      <= s2_x_d;
            s2_y_q      <= s2_y_d;
            new_frame_q <= new_frame_d;
            busy_q      <= busy_d;
            dropped_q   <= dropped_d;
        end
    end

    xilinx_true_dual_port_read_first_2_clock_ram #(
        .RAM_WIDTH (1),
        .RAM_DEPTH (RAM_DEPTH)
    ) u_ram (
        .clka   (clk_in),
        .ena    (1'b1),
        .wea    (w_wr_en),
        .addra  ({wr_bank_q, w_wr_off}),
        .dina   (wr_mask_in),
        .clkb   (clk_in),
        .enb    (~stall_in),
        .regceb (~stall_in),
        .addrb  ({rd_bank_q, w_rd_off}),
        .doutb  (w_ram_dout)
    );

    // RAM output is not reset, so it is qualified by the pipeline valid.
    assign mask_out           = w_ram_dout & s2_valid_q;
    assign x_out              = s2_x_q;
    assign y_out              = s2_y_q;
    assign valid_out          = s2_valid_q & ~stall_in;
    assign new_frame_out      = new_frame_q;
    assign busy_out           = busy_q;
    assign frames_dropped_out = dropped_q;

endmodule
`default_nettype wire
